fcb_wff_dispatch: RTL and testbench

//  Consumer end of the FCB write FIFO; the APB slave is the producer. Pops 40-bit entries and

---
 rtl/fcb_pkg.sv | 20 ++
 rtl/fcb_wdp_timeout.sv | 35 +++
 rtl/fcb_wff_dispatch.sv | 175 +++++++++++++++++
 tb/tb_fcb_wff_dispatch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcb_pkg.sv
// Shared types and entry-field layout for the FCB write-FIFO dispatcher.
package fcb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SFRW = 3'd1,
        S_SFRR = 3'd2,
        S_PUSH = 3'd3,
        S_CFGW = 3'd4
    } fcb_state_e;

    localparam int WFF_RW_BIT   = 39;
    localparam int WFF_ADDR_MSB = 38;
    localparam int WFF_ADDR_LSB = 32;
    localparam int WFF_DATA_MSB = 31;

    // Substituted for SFR read data when the SFR never acknowledges.
    localparam logic [31:0] CRF_TO_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/fcb_wdp_timeout.sv
// SFR ack watchdog: down-counter reloaded while idle, terminal count flags expiry.
// Only instantiated when FCB_WDP_SFR_TIMEOUT_EN is defined.
module fcb_wdp_timeout #(
    parameter logic [15:0] TO_CYC = 16'd1024
) (
    input  logic fcb_sys_clk,
    input  logic fcb_sys_rst_n,
    input  logic active,
    output logic expired
);

    localparam logic [15:0] LOAD_VAL = TO_CYC - 16'd1;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Reload on every inactive cycle so each SFR access starts a full window.
    always_comb begin
        cnt_d = LOAD_VAL;
        if (active) begin
            cnt_d = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
        end
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = active && (cnt_q == 16'd0);

endmodule

// File: rtl/fcb_wff_dispatch.sv
// Consumer of the FCB write FIFO: dispatches entries as SFR write/read or config-datapath write.
// Optional SFR ack timeout enabled by defining FCB_WDP_SFR_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for a write-FIFO entry; pops and decodes it
// S_SFRW | SFR write request held until ack
// S_SFRR | SFR read request held until ack
// S_PUSH | read data waiting for room in the Cfg Read FIFO
// S_CFGW | config datapath write waiting for not-busy
module fcb_wff_dispatch
    import fcb_pkg::*;
#(
    parameter logic [6:0]  PAR_CFGDP_ADDR = 7'h20
`ifdef FCB_WDP_SFR_TIMEOUT_EN
   ,parameter logic [15:0] PAR_TO_CYC     = 16'd1024
`endif
) (
    input  logic        fcb_sys_clk,
    input  logic        fcb_sys_rst_n,
    input  logic        frwf_wff_empty,
    input  logic [39:0] frwf_wff_rd_data,
    output logic        fwdp_wff_rd_en,
    input  logic        frwf_crf_full,
    output logic        fwdp_crf_wr_en,
    output logic [31:0] fwdp_crf_wr_data,
    output logic [6:0]  fwdp_sfr_addr,
    output logic        fwdp_sfr_wr_en,
    output logic        fwdp_sfr_rd_en,
    output logic [31:0] fwdp_sfr_wdata,
    input  logic [31:0] fsfr_fwdp_rdata,
    input  logic        fsfr_fwdp_ack,
    output logic        fwdp_cfg_wr_en,
    output logic [31:0] fwdp_cfg_wr_data,
    input  logic        fcfg_fwdp_busy,
    output logic        fwdp_sfr_err
);

    fcb_state_e  state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        run_q;
    logic        to_expired;

    logic        ent_rw;
    logic [6:0]  ent_addr;
    logic [31:0] ent_data;

    assign ent_rw   = frwf_wff_rd_data[WFF_RW_BIT];
    assign ent_addr = frwf_wff_rd_data[WFF_ADDR_MSB:WFF_ADDR_LSB];
    assign ent_data = frwf_wff_rd_data[WFF_DATA_MSB:0];

`ifdef FCB_WDP_SFR_TIMEOUT_EN
    logic err_q, err_d;

    fcb_wdp_timeout #(
        .TO_CYC (PAR_TO_CYC)
    ) u_timeout (
        .fcb_sys_clk   (fcb_sys_clk),
        .fcb_sys_rst_n (fcb_sys_rst_n),
        .active        ((state_q == S_SFRW) || (state_q == S_SFRR)),
        .expired       (to_expired)
    );

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fwdp_sfr_err = err_q;
`else
    assign to_expired   = 1'b0;
    assign fwdp_sfr_err = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        fwdp_wff_rd_en   = 1'b0;
        fwdp_crf_wr_en   = 1'b0;
        fwdp_crf_wr_data = 32'd0;
        fwdp_sfr_addr    = 7'd0;
        fwdp_sfr_wr_en   = 1'b0;
        fwdp_sfr_rd_en   = 1'b0;
        fwdp_sfr_wdata   = 32'd0;
        fwdp_cfg_wr_en   = 1'b0;
        fwdp_cfg_wr_data = 32'd0;
`ifdef FCB_WDP_SFR_TIMEOUT_EN
        err_d            = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                // run_q keeps the pop strobe low while reset is asserted.
                if (run_q && !frwf_wff_empty) begin
                    fwdp_wff_rd_en = 1'b1;
                    addr_d         = ent_addr;
                    data_d         = ent_data;
                    if (ent_rw && (ent_addr == PAR_CFGDP_ADDR)) begin
                        state_d = S_CFGW;
                    end else if (ent_rw) begin
                        state_d = S_SFRW;
                    end else begin
                        state_d = S_SFRR;
                    end
                end
            end

            S_SFRW: begin
                fwdp_sfr_wr_en = 1'b1;
                fwdp_sfr_addr  = addr_q;
                fwdp_sfr_wdata = data_q;
                if (fsfr_fwdp_ack) begin
                    state_d = S_IDLE;
                end else if (to_expired) begin
                    state_d = S_IDLE;
`ifdef FCB_WDP_SFR_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end

            S_SFRR: begin
                fwdp_sfr_rd_en = 1'b1;
                fwdp_sfr_addr  = addr_q;
                if (fsfr_fwdp_ack) begin
                    data_d  = fsfr_fwdp_rdata;
                    state_d = S_PUSH;
                end else if (to_expired) begin
                    data_d  = CRF_TO_PATTERN;
                    state_d = S_PUSH;
`ifdef FCB_WDP_SFR_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end

            S_PUSH: begin
                if (!frwf_crf_full) begin
                    fwdp_crf_wr_en   = 1'b1;
                    fwdp_crf_wr_data = data_q;
                    state_d          = S_IDLE;
                end
            end

            S_CFGW: begin
                if (!fcfg_fwdp_busy) begin
                    fwdp_cfg_wr_en   = 1'b1;
                    fwdp_cfg_wr_data = data_q;
                    state_d          = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 7'd0;
            data_q  <= 32'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fcb_wff_dispatch.sv
// Directed bench for fcb_wff_dispatch; timeout scenario runs when FCB_WDP_SFR_TIMEOUT_EN is defined.
module tb_fcb_wff_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wff_empty;
    logic [39:0] wff_data;
    logic        wff_rd_en;
    logic        crf_full;
    logic        crf_wr_en;
    logic [31:0] crf_wr_data;
    logic [6:0]  sfr_addr;
    logic        sfr_wr_en;
    logic        sfr_rd_en;
    logic [31:0] sfr_wdata;
    logic [31:0] sfr_rdata;
    logic        sfr_ack;
    logic        cfg_wr_en;
    logic [31:0] cfg_wr_data;
    logic        cfg_busy;
    logic        sfr_err;

    int n_vec  = 0;
    int n_miss = 0;

    fcb_wff_dispatch #(
        .PAR_CFGDP_ADDR (7'h20)
`ifdef FCB_WDP_SFR_TIMEOUT_EN
       ,.PAR_TO_CYC     (16'd16)
`endif
    ) dut (
        .fcb_sys_clk      (clk),
        .fcb_sys_rst_n    (rst_n),
        .frwf_wff_empty   (wff_empty),
        .frwf_wff_rd_data (wff_data),
        .fwdp_wff_rd_en   (wff_rd_en),
        .frwf_crf_full    (crf_full),
        .fwdp_crf_wr_en   (crf_wr_en),
        .fwdp_crf_wr_data (crf_wr_data),
        .fwdp_sfr_addr    (sfr_addr),
        .fwdp_sfr_wr_en   (sfr_wr_en),
        .fwdp_sfr_rd_en   (sfr_rd_en),
        .fwdp_sfr_wdata   (sfr_wdata),
        .fsfr_fwdp_rdata  (sfr_rdata),
        .fsfr_fwdp_ack    (sfr_ack),
        .fwdp_cfg_wr_en   (cfg_wr_en),
        .fwdp_cfg_wr_data (cfg_wr_data),
        .fcfg_fwdp_busy   (cfg_busy),
        .fwdp_sfr_err     (sfr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " wr_en"},  40'(sfr_wr_en), 40'd0);
        chk({tag, " rd_en"},  40'(sfr_rd_en), 40'd0);
        chk({tag, " addr"},   40'(sfr_addr),  40'd0);
        chk({tag, " wdata"},  40'(sfr_wdata), 40'd0);
        chk({tag, " crf_en"}, 40'(crf_wr_en), 40'd0);
        chk({tag, " crf_d"},  40'(crf_wr_data), 40'd0);
        chk({tag, " cfg_en"}, 40'(cfg_wr_en), 40'd0);
        chk({tag, " cfg_d"},  40'(cfg_wr_data), 40'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wff_empty = 1'b0;
        wff_data  = {1'b1, 7'h05, 32'h1234_5678};
        crf_full  = 1'b0;
        sfr_rdata = 32'd0;
        sfr_ack   = 1'b0;
        cfg_busy  = 1'b0;

        // Reset with a pending entry: nothing may be popped or driven.
        #1;
        chk("rst pop", 40'(wff_rd_en), 40'd0);
        chk_quiet("rst");
        chk("rst err", 40'(sfr_err), 40'd0);
        cyc();
        cyc();
        chk("rst pop2", 40'(wff_rd_en), 40'd0);
        wff_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: SFR write, ack on third request cycle.
        cyc();
        wff_empty = 1'b0;
        wff_data  = {1'b1, 7'h05, 32'h1234_5678};
        smp();
        chk("w pop", 40'(wff_rd_en), 40'd1);
        chk("w req0", 40'(sfr_wr_en), 40'd0);
        cyc();
        wff_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) sfr_ack = 1'b1;
            smp();
            chk("w wr_en", 40'(sfr_wr_en), 40'd1);
            chk("w addr",  40'(sfr_addr),  40'h05);
            chk("w wdata", 40'(sfr_wdata), 40'h1234_5678);
            chk("w pop0",  40'(wff_rd_en), 40'd0);
            chk("w crf",   40'(crf_wr_en), 40'd0);
            cyc();
        end
        sfr_ack = 1'b0;
        smp();
        chk("w drop", 40'(wff_rd_en), 40'd0);
        chk_quiet("w after");
        chk("w err", 40'(sfr_err), 40'd0);

        // Test 2: SFR read, CRF full for 4 cycles.
        cyc();
        wff_empty = 1'b0;
        wff_data  = {1'b0, 7'h0A, 32'h0};
        smp();
        chk("r pop", 40'(wff_rd_en), 40'd1);
        cyc();
        wff_empty = 1'b1;
        smp();
        chk("r rd_en", 40'(sfr_rd_en), 40'd1);
        chk("r addr",  40'(sfr_addr),  40'h0A);
        chk("r wr_en", 40'(sfr_wr_en), 40'd0);
        cyc();
        sfr_ack   = 1'b1;
        sfr_rdata = 32'hCAFE_0001;
        crf_full  = 1'b1;
        smp();
        chk("r rd_ack", 40'(sfr_rd_en), 40'd1);
        chk("r crf_ack", 40'(crf_wr_en), 40'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            sfr_ack   = 1'b0;
            sfr_rdata = 32'd0;
            smp();
            chk("r full crf", 40'(crf_wr_en), 40'd0);
            chk("r full d",   40'(crf_wr_data), 40'd0);
            chk("r full rd",  40'(sfr_rd_en), 40'd0);
        end
        cyc();
        crf_full = 1'b0;
        smp();
        chk("r push", 40'(crf_wr_en), 40'd1);
        chk("r push d", 40'(crf_wr_data), 40'hCAFE_0001);
        cyc();
        smp();
        chk_quiet("r after");

        // Test 3: config write with busy.
        cyc();
        wff_empty = 1'b0;
        wff_data  = {1'b1, 7'h20, 32'hA5A5_A5A5};
        cfg_busy  = 1'b1;
        smp();
        chk("c pop", 40'(wff_rd_en), 40'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            wff_empty = 1'b1;
            smp();
            chk_quiet("c busy");
        end
        cyc();
        cfg_busy = 1'b0;
        smp();
        chk("c en", 40'(cfg_wr_en), 40'd1);
        chk("c d",  40'(cfg_wr_data), 40'hA5A5_A5A5);
        chk("c sfr", 40'(sfr_wr_en), 40'd0);
        cyc();
        smp();
        chk_quiet("c after");

        // Test 4: three back-to-back writes, immediate ack, FIFO never empty while busy.
        for (int k = 1; k <= 3; k++) begin
            cyc();
            sfr_ack   = 1'b0;
            wff_empty = 1'b0;
            wff_data  = {1'b1, 7'(k), {4{8'(k * 17)}}};
            smp();
            chk("b pop", 40'(wff_rd_en), 40'd1);
            chk("b idle", 40'(sfr_wr_en), 40'd0);
            cyc();
            wff_empty = (k == 3);
            wff_data  = {1'b1, 7'(k + 1), {4{8'((k + 1) * 17)}}};
            sfr_ack   = 1'b1;
            smp();
            chk("b nopop", 40'(wff_rd_en), 40'd0);
            chk("b wr_en", 40'(sfr_wr_en), 40'd1);
            chk("b addr",  40'(sfr_addr),  40'(k));
            chk("b wdata", 40'(sfr_wdata), 40'({4{8'(k * 17)}}));
        end
        // Stray ack while idle is ignored.
        cyc();
        smp();
        chk("b extra pop", 40'(wff_rd_en), 40'd0);
        chk_quiet("b stray ack");
        cyc();
        sfr_ack = 1'b0;
        smp();
        chk_quiet("b after");

        // Test 5: reset during an SFR read.
        cyc();
        wff_empty = 1'b0;
        wff_data  = {1'b0, 7'h11, 32'h0};
        smp();
        chk("x pop", 40'(wff_rd_en), 40'd1);
        cyc();
        wff_data = {1'b1, 7'h06, 32'h0000_0066};
        smp();
        chk("x rd_en", 40'(sfr_rd_en), 40'd1);
        chk("x nopop", 40'(wff_rd_en), 40'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x rst pop", 40'(wff_rd_en), 40'd0);
        chk_quiet("x rst");
        cyc();
        wff_empty = 1'b1;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        sfr_ack   = 1'b1;
        sfr_rdata = 32'h0000_1234;
        smp();
        chk_quiet("x post1");
        cyc();
        sfr_ack   = 1'b0;
        sfr_rdata = 32'd0;
        smp();
        chk_quiet("x post2");

`ifdef FCB_WDP_SFR_TIMEOUT_EN
        // Test 6: read never acknowledged, 16-cycle timeout.
        cyc();
        wff_empty = 1'b0;
        wff_data  = {1'b0, 7'h33, 32'h0};
        smp();
        chk("t pop", 40'(wff_rd_en), 40'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            wff_empty = 1'b1;
            smp();
            chk("t rd_en", 40'(sfr_rd_en), 40'd1);
            chk("t err0",  40'(sfr_err),   40'd0);
        end
        cyc();
        smp();
        chk("t drop", 40'(sfr_rd_en), 40'd0);
        chk("t push", 40'(crf_wr_en), 40'd1);
        chk("t data", 40'(crf_wr_data), 40'hDEAD_BEEF);
        chk("t err",  40'(sfr_err), 40'd1);
        cyc();
        smp();
        chk("t sticky", 40'(sfr_err), 40'd1);
        chk("t crf0", 40'(crf_wr_en), 40'd0);
`else
        chk("no-timeout err", 40'(sfr_err), 40'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
